aer_event_sender: RTL
=====================

Name: aer_event_sender

Overview:
- Downstream of the intensity sorter. Takes each sorted pixel index, or AER reset marker, and transmits it as a bundled-data, 4-phase REQ/ACK event to the SNN core's AER input.
- Drives AERIN_CTRL_BUSY back to the sorter so that only one event is in flight at a time.
- Keeps per-image event counters and sticky error flags for the top-level controller.

Parameters:
- IMAGE_SIZE, 256, number of pixels/input neurons.
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), pixel index width.
- AER_WIDTH, IMAGE_SIZE_BITS+2, address width; matches the sorter's NEXT_INDEX width.
- RST_MARKER, {1'b0,1'b1,8'hFF} (0x1FF at defaults), address that denotes an AER reset event.
- ACK_SYNC_STAGES, 2, flops in the ACK synchroniser (minimum 2).
- TIMEOUT_CYCLES, 1023, maximum cycles waiting for either ACK edge.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset. Synchronous, active-high; sampled only on the rising edge of CLK.
- NEXT_INDEX  in  AER_WIDTH  event address from the sorter.
- FOUND_NEXT_INDEX  in  1  one-cycle strobe; NEXT_INDEX is valid in the same cycle.
- CLEAR  in  1  synchronous clear of counters and error flags (pulsed on NEW_IMAGE).
- AERIN_CTRL_BUSY  out  1  high while an event is accepted but its handshake is not complete.
- AERIN_ADDR  out  AER_WIDTH  registered AER address.
- AERIN_REQ  out  1  AER request.
- AERIN_ACK  in  1  AER acknowledge, asynchronous to CLK.
- PIXEL_EVENT_CNT  out  IMAGE_SIZE_BITS+1  completed handshakes with address != RST_MARKER; saturating.
- RST_EVENT_CNT  out  2  completed handshakes with address == RST_MARKER; saturating.
- TIMEOUT_ERR  out  1  sticky: a handshake phase exceeded TIMEOUT_CYCLES.
- OVERRUN_ERR  out  1  sticky: FOUND_NEXT_INDEX arrived while busy.

Behaviour:
- Reset (RST high at an edge): every output goes to 0; AERIN_ADDR = 0; state = IDLE; timeout counter = 0; synchroniser flops = 0.
- ACK synchronisation: ack_s is AERIN_ACK after ACK_SYNC_STAGES flops. All FSM decisions use ack_s only.
- IDLE:
  - On FOUND_NEXT_INDEX: AERIN_ADDR <= NEXT_INDEX; BUSY <= 1; go to SETUP.
  - BUSY is therefore high on the cycle after the strobe, which is the cycle the sorter samples it.
- SETUP (one cycle, address setup for bundled data): AERIN_REQ <= 1; go to REQ_HI.
- REQ_HI:
  - On ack_s = 1: AERIN_REQ <= 0; go to REQ_LO.
  - If the timeout counter reaches TIMEOUT_CYCLES first: TIMEOUT_ERR <= 1; AERIN_REQ <= 0; go to REQ_LO.
- REQ_LO:
  - On ack_s = 0: go to COMPLETE.
  - On timeout: TIMEOUT_ERR <= 1; go to IDLE with BUSY <= 0; no counter update.
- COMPLETE (one cycle):
  - Increment PIXEL_EVENT_CNT or RST_EVENT_CNT according to AERIN_ADDR, unless a timeout occurred during this event.
  - BUSY <= 0; go to IDLE.
- Timeout counter: cleared on every state change; increments each cycle spent in REQ_HI or REQ_LO.
- Latency: strobe to REQ rise = 2 cycles. Ideal ACK (no sync delay) gives BUSY low 2 + 2*ACK_SYNC_STAGES + 3 cycles after the strobe, minimum.
- AERIN_ADDR is held constant from capture until the next capture.
- FOUND_NEXT_INDEX in any state other than IDLE: ignored; OVERRUN_ERR <= 1; the event in flight is unaffected.
- CLEAR: zeroes both counters and both error flags on the next edge. It does not affect the FSM, REQ, ADDR or BUSY.
- CLEAR on the same edge as a COMPLETE increment: CLEAR wins, and the counter ends at 0.
- Counters saturate at all-ones and never wrap.
- RST mid-handshake: REQ drops to 0 at that edge and BUSY clears. The core is responsible for its own ACK return; no residual state remains.
- A NEXT_INDEX value ≥ IMAGE_SIZE that is not RST_MARKER is still sent and counted as a pixel event. Address range checking is not this block's job.

Test Plan:
- Reset, then strobe with NEXT_INDEX = 0x1FF; ACK model raises ACK 3 cycles after REQ and drops it 3 cycles after REQ falls -> ADDR = 0x1FF; REQ rises 2 cycles after the strobe; BUSY high from strobe+1 until COMPLETE; RST_EVENT_CNT = 1; PIXEL_EVENT_CNT = 0.
- Two marker events, then 256 strobes with indexes 255 down to 0, each issued only after BUSY drops -> RST_EVENT_CNT = 2; PIXEL_EVENT_CNT = 256; ADDR sequence matches the input; no errors.
- Strobe with ACK held at 0 -> REQ drops and TIMEOUT_ERR = 1 at REQ rise + TIMEOUT_CYCLES + 1; then returns to IDLE; no counter change.
- Second strobe 1 cycle after the first -> OVERRUN_ERR = 1; ADDR keeps the first value; exactly one handshake occurs.
- RST asserted while in REQ_HI -> next cycle REQ = 0, BUSY = 0, counters = 0; a following strobe with index 7 completes normally with PIXEL_EVENT_CNT = 1.
- CLEAR pulsed on the same edge as a COMPLETE with counters at 5 -> PIXEL_EVENT_CNT = 0 after the edge; FSM reaches IDLE normally.

Source files
------------

// File: rtl/aer_event_sender.sv
// aer_event_sender: sends sorted pixel indexes (or the AER reset marker) to the
// SNN core as bundled-data, 4-phase REQ/ACK events. Only one event is in flight
// at a time; AERIN_CTRL_BUSY tells the sorter when the sender can take another.
// Per-image event counters and sticky error flags feed the top-level controller.
module aer_event_sender #(
  parameter int                    IMAGE_SIZE      = 256,
  parameter int                    IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int                    AER_WIDTH       = IMAGE_SIZE_BITS + 2,
  parameter logic [AER_WIDTH-1:0]  RST_MARKER      = AER_WIDTH'({2'b01, {IMAGE_SIZE_BITS{1'b1}}}),
  parameter int                    ACK_SYNC_STAGES = 2,
  parameter int                    TIMEOUT_CYCLES  = 1023
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [AER_WIDTH-1:0]       NEXT_INDEX,
  input  logic                       FOUND_NEXT_INDEX,
  input  logic                       CLEAR,
  output logic                       AERIN_CTRL_BUSY,
  output logic [AER_WIDTH-1:0]       AERIN_ADDR,
  output logic                       AERIN_REQ,
  input  logic                       AERIN_ACK,
  output logic [IMAGE_SIZE_BITS:0]   PIXEL_EVENT_CNT,
  output logic [1:0]                 RST_EVENT_CNT,
  output logic                       TIMEOUT_ERR,
  output logic                       OVERRUN_ERR
);

  localparam int PIX_W = IMAGE_SIZE_BITS + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ_HI,
    S_REQ_LO,
    S_COMPLETE
  } state_t;

  state_t                 state, state_nxt;
  logic [ACK_SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [TMO_W-1:0]       tmo_cnt, tmo_cnt_nxt;
  logic                   in_phase;
  logic                   tmo_hit;
  // Remembers that the current event timed out so COMPLETE does not count it.
  logic                   evt_tmo, evt_tmo_nxt;

  logic [AER_WIDTH-1:0]   addr_nxt;
  logic                   req_nxt;
  logic                   busy_nxt;
  logic [PIX_W-1:0]       pix_cnt_nxt;
  logic [1:0]             rst_cnt_nxt;
  logic                   tmo_err_nxt;
  logic                   ovr_err_nxt;

  // ACK synchroniser: AERIN_ACK is asynchronous, so only ack_s is ever used.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[ACK_SYNC_STAGES-2:0], AERIN_ACK};
    end
  end

  assign ack_s    = ack_sync[ACK_SYNC_STAGES-1];
  assign in_phase = (state == S_REQ_HI) || (state == S_REQ_LO);
  assign tmo_hit  = in_phase && (tmo_cnt == TMO_MAX);

  // State register: FSM state plus every registered output and datapath flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= S_IDLE;
      tmo_cnt         <= '0;
      evt_tmo         <= 1'b0;
      AERIN_ADDR      <= '0;
      AERIN_REQ       <= 1'b0;
      AERIN_CTRL_BUSY <= 1'b0;
      PIXEL_EVENT_CNT <= '0;
      RST_EVENT_CNT   <= '0;
      TIMEOUT_ERR     <= 1'b0;
      OVERRUN_ERR     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state           <= state_nxt;
      tmo_cnt         <= tmo_cnt_nxt;
      evt_tmo         <= evt_tmo_nxt;
      AERIN_ADDR      <= addr_nxt;
      AERIN_REQ       <= req_nxt;
      AERIN_CTRL_BUSY <= busy_nxt;
      PIXEL_EVENT_CNT <= pix_cnt_nxt;
      RST_EVENT_CNT   <= rst_cnt_nxt;
      TIMEOUT_ERR     <= tmo_err_nxt;
      OVERRUN_ERR     <= ovr_err_nxt;
    end
  end

  // Next-state logic: handshake sequencing with a per-phase timeout escape.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (FOUND_NEXT_INDEX) state_nxt = S_SETUP;
      S_SETUP:    state_nxt = S_REQ_HI;
      S_REQ_HI:   if (ack_s || tmo_hit) state_nxt = S_REQ_LO;
      S_REQ_LO: begin
        if (!ack_s)       state_nxt = S_COMPLETE;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_COMPLETE: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of REQ/BUSY/ADDR, timeout counter, counters and flags.
  always_comb begin
    addr_nxt    = AERIN_ADDR;
    req_nxt     = AERIN_REQ;
    busy_nxt    = AERIN_CTRL_BUSY;
    evt_tmo_nxt = evt_tmo;
    pix_cnt_nxt = PIXEL_EVENT_CNT;
    rst_cnt_nxt = RST_EVENT_CNT;
    tmo_err_nxt = TIMEOUT_ERR;
    ovr_err_nxt = OVERRUN_ERR;

    unique case (state)
      S_IDLE: begin
        if (FOUND_NEXT_INDEX) begin
          addr_nxt    = NEXT_INDEX;
          busy_nxt    = 1'b1;
          evt_tmo_nxt = 1'b0;
        end
      end
      S_SETUP: begin
        // Address has had a full cycle to settle before REQ rises.
        req_nxt = 1'b1;
      end
      S_REQ_HI: begin
        if (ack_s) begin
          req_nxt = 1'b0;
        end else if (tmo_hit) begin
          req_nxt     = 1'b0;
          tmo_err_nxt = 1'b1;
          evt_tmo_nxt = 1'b1;
        end
      end
      S_REQ_LO: begin
        if (ack_s && tmo_hit) begin
          tmo_err_nxt = 1'b1;
          busy_nxt    = 1'b0;
        end
      end
      S_COMPLETE: begin
        busy_nxt = 1'b0;
        if (!evt_tmo) begin
          if (AERIN_ADDR == RST_MARKER) begin
            if (!(&RST_EVENT_CNT)) rst_cnt_nxt = RST_EVENT_CNT + 2'd1;
          end else begin
            if (!(&PIXEL_EVENT_CNT)) pix_cnt_nxt = PIXEL_EVENT_CNT + PIX_W'(1);
          end
        end
      end
      default: ;
    endcase

    // A strobe while an event is in flight is dropped and flagged.
    if (FOUND_NEXT_INDEX && (state != S_IDLE)) ovr_err_nxt = 1'b1;

    // CLEAR has the last word on counters and flags, even over a COMPLETE.
    if (CLEAR) begin
      pix_cnt_nxt = '0;
      rst_cnt_nxt = '0;
      tmo_err_nxt = 1'b0;
      ovr_err_nxt = 1'b0;
    end

    // Timeout counter restarts on every state change and runs only in REQ phases.
    if (state_nxt != state)  tmo_cnt_nxt = '0;
    else if (in_phase)       tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
    else                     tmo_cnt_nxt = '0;
  end

endmodule
